// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR frame sequencer.
//   fir_state_e  - sequencer state encoding
//   flush_lines  - flush lines needed to drain TAP_NUMS vertical taps
//   H_MIN/V_MIN  - smallest legal frame dimensions
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_GAP    = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } fir_state_e;

    localparam int H_MIN = 2;
    localparam int V_MIN = 1;

    // Lines still owed by the vertical window after the last input line.
    function automatic int flush_lines(input int taps);
        return (taps - 1) / 2;
    endfunction

endpackage

// File: rtl/fir_raster_cnt.sv
// fir_raster_cnt: raster position counters for the frame sequencer.
//   clear_i    - zero all counters (accepted frame start)
//   advance_i  - one pixel consumed by the line buffer this cycle
//   gap_i      - sequencer is in an inter-line gap this cycle
//   h_size_i   - latched pixels per line
//   v_size_i   - latched input lines per frame
//   line_idx_o - current line index, flush lines included
//   eol_o      - this advance completes the line
//   gap_done_o - last cycle of the gap (qualify with gap state)
//   img_end_o  - all input lines have been consumed
//   eof_o      - all input and flush lines have been consumed
module fir_raster_cnt #(
    parameter int LINE_CNT    = 12,
    parameter int GAP_CYCLES  = 2,
    parameter int FLUSH_LINES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                advance_i,
    input  logic                gap_i,
    input  logic [LINE_CNT-1:0] h_size_i,
    input  logic [LINE_CNT-1:0] v_size_i,
    output logic [LINE_CNT-1:0] line_idx_o,
    output logic                eol_o,
    output logic                gap_done_o,
    output logic                img_end_o,
    output logic                eof_o
);

    localparam int GW  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int LW1 = LINE_CNT + 1;

    logic [LINE_CNT-1:0] pix_cnt_q, pix_cnt_d;
    logic [LINE_CNT-1:0] line_idx_q, line_idx_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;

    assign eol_o      = advance_i && (pix_cnt_q == h_size_i - LINE_CNT'(1));
    assign gap_done_o = (gap_cnt_q == '0);
    assign img_end_o  = (line_idx_q >= v_size_i);
    // One extra bit so v_size + FLUSH_LINES cannot wrap at the top of the range.
    assign eof_o      = ({1'b0, line_idx_q} >= ({1'b0, v_size_i} + LW1'(FLUSH_LINES)));
    assign line_idx_o = line_idx_q;

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        line_idx_d = line_idx_q;
        gap_cnt_d  = gap_cnt_q;
        if (clear_i) begin
            pix_cnt_d  = '0;
            line_idx_d = '0;
            gap_cnt_d  = '0;
        end else begin
            if (eol_o) begin
                pix_cnt_d  = '0;
                line_idx_d = line_idx_q + LINE_CNT'(1);
                // Down-counter preloaded so the gap lasts exactly GAP_CYCLES.
                gap_cnt_d  = GW'(GAP_CYCLES - 1);
            end else if (advance_i) begin
                pix_cnt_d  = pix_cnt_q + LINE_CNT'(1);
            end
            if (gap_i && gap_cnt_q != '0) begin
                gap_cnt_d = gap_cnt_q - GW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q  <= '0;
            line_idx_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            line_idx_q <= line_idx_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

endmodule

// File: rtl/fir_frame_sequencer.sv
// fir_frame_sequencer: frame scheduler in front of the 2D FIR line-buffer
// controller. Streams raster pixels into the controller, inserts gaps after
// each line so its write-back pipeline drains, injects flush lines after the
// last input line and pulses done_o when the frame is complete.
//   start_i/h_size_i/v_size_i - frame start and sizes (sampled in IDLE)
//   s_valid_i/s_data_i/s_ready_o - input pixel handshake
//   lb_*         - line-buffer controller drive (combinational from state)
//   line_idx_o   - current line, flush lines included
//   busy_o/done_o/cfg_err_o - status; done_o and cfg_err_o are 1-cycle pulses
module fir_frame_sequencer
    import fir_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 8,
    parameter int                  LINE_CNT    = 12,
    parameter int                  TAP_NUMS    = 3,
    parameter int                  GAP_CYCLES  = 2,
    parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [LINE_CNT-1:0]   h_size_i,
    input  logic [LINE_CNT-1:0]   v_size_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic                  lb_ce_o,
    output logic [DATA_WIDTH-1:0] lb_pixel_o,
    output logic                  lb_first_ln_o,
    output logic                  lb_rd_en_o,
    output logic [LINE_CNT-1:0]   lb_h_size_o,
    output logic [LINE_CNT-1:0]   line_idx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o
);

    localparam int FLUSH_LINES = flush_lines(TAP_NUMS);

    fir_state_e          state_q, state_d;
    logic [LINE_CNT-1:0] h_size_q, h_size_d;
    logic [LINE_CNT-1:0] v_size_q, v_size_d;
    logic                cfg_err_q, cfg_err_d;

    logic start_ok, clear, advance, in_gap;
    logic eol, gap_done, img_end, eof;

    assign start_ok = (h_size_i >= LINE_CNT'(H_MIN)) && (v_size_i >= LINE_CNT'(V_MIN));
    assign in_gap   = (state_q == ST_GAP);
    // Flush lines feed the controller every cycle; input lines only on beats.
    assign advance  = (state_q == ST_FLUSH) || ((state_q == ST_ACTIVE) && s_valid_i);
    assign clear    = (state_q == ST_IDLE) && start_i && start_ok;

    fir_raster_cnt #(
        .LINE_CNT   (LINE_CNT),
        .GAP_CYCLES (GAP_CYCLES),
        .FLUSH_LINES(FLUSH_LINES)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .advance_i (advance),
        .gap_i     (in_gap),
        .h_size_i  (h_size_q),
        .v_size_i  (v_size_q),
        .line_idx_o(line_idx_o),
        .eol_o     (eol),
        .gap_done_o(gap_done),
        .img_end_o (img_end),
        .eof_o     (eof)
    );

    always_comb begin
        state_d   = state_q;
        h_size_d  = h_size_q;
        v_size_d  = v_size_q;
        cfg_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (start_ok) begin
                        state_d  = ST_ACTIVE;
                        h_size_d = h_size_i;
                        v_size_d = v_size_i;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE, ST_FLUSH: begin
                if (eol) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_done) begin
                    if (!img_end)  state_d = ST_ACTIVE;
                    else if (!eof) state_d = ST_FLUSH;
                    else           state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            h_size_q  <= '0;
            v_size_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_size_q  <= h_size_d;
            v_size_q  <= v_size_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Status decoded from registered state only (no path from s_valid_i).
    assign s_ready_o   = (state_q == ST_ACTIVE);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign cfg_err_o   = cfg_err_q;
    assign lb_h_size_o = h_size_q;

    always_comb begin
        lb_ce_o       = 1'b0;
        lb_pixel_o    = '0;
        lb_first_ln_o = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                lb_ce_o       = s_valid_i;
                lb_pixel_o    = s_data_i;
                lb_first_ln_o = (line_idx_o == '0);
            end
            ST_FLUSH: begin
                lb_ce_o       = 1'b1;
                lb_pixel_o    = FLUSH_VALUE;
                // A single-line frame treats every line, flush included, as first.
                lb_first_ln_o = (v_size_q == LINE_CNT'(1));
            end
            default: ;
        endcase
    end

    assign lb_rd_en_o = lb_ce_o & ~lb_first_ln_o;

endmodule
